// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_ERROR    = 2'd3
  } pipe_state_e;

  // Stage indices; enable[s] loads the register feeding stage s (IF -> pc)
  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;
  localparam int unsigned NUM_STG = 5;

  localparam int unsigned REG_W = 5;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the EX load and the ID operands.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real dependency, so a load to x0 cannot stall
  always_comb begin
    rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
    load_use_c = ex_valid && ex_is_load && (ex_rd != '0) && id_valid
                 && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: hazard priority, memory-wait FSM,
// stage-valid tracking and a saturating stall-cycle counter.
module pipeline_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             halted,
  output logic             err
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  pipe_state_e state_q, state_d;
  logic [NUM_STG-1:STG_ID] vld_q, vld_d, vld_up;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic                    halted_q, halted_d;
  logic                    err_q, err_d;

  logic [NUM_STG-1:0]      en_c;
  logic [NUM_STG-1:STG_ID] flush_c;
  logic                    active_c;
  logic                    mem_stall_c;
  logic                    redirect_c;
  logic                    load_use_c;

  hazard_detect u_hazard_detect (
    .id_valid   (vld_q[STG_ID]),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (vld_q[STG_EX]),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .load_use_c (load_use_c)
  );

  // Enable/flush decode in priority order; MEM_WAIT without a stall acts as RUN
  always_comb begin
    en_c        = '1;
    flush_c     = '0;
    active_c    = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    mem_stall_c = vld_q[STG_MEM] && mem_req && !mem_ready;
    redirect_c  = vld_q[STG_EX] && ex_redirect;
    if (!active_c) begin
      en_c = '0;
    end else if (mem_stall_c) begin
      en_c[STG_IF]     = 1'b0;
      en_c[STG_ID]     = 1'b0;
      en_c[STG_EX]     = 1'b0;
      en_c[STG_MEM]    = 1'b0;
      flush_c[STG_WB]  = 1'b1;
    end else if (redirect_c) begin
      flush_c[STG_ID]  = 1'b1;
      flush_c[STG_EX]  = 1'b1;
    end else if (load_use_c) begin
      en_c[STG_IF]     = 1'b0;
      en_c[STG_ID]     = 1'b0;
      flush_c[STG_EX]  = 1'b1;
    end else if (!imem_ready) begin
      en_c[STG_IF]     = 1'b0;
      flush_c[STG_ID]  = 1'b1;
    end
  end

  // Next state, wait counter and sticky indicators
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (vld_q[STG_WB] && wb_halt) begin
          state_d = ST_HALT;
        end else if (mem_stall_c) begin
          if ((32'(wait_q) + 32'd1) >= 32'(MEM_TIMEOUT)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_MEM_WAIT;
            wait_d  = wait_q + WAIT_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = state_q;
    endcase
    halted_d = (state_d == ST_HALT);
    err_d    = (state_d == ST_ERROR);
  end

  // Valid bits follow their enables; a flush inserts a bubble
  always_comb begin
    vld_up = {vld_q[NUM_STG-2:STG_ID], imem_ready};
    vld_d  = vld_q;
    for (int unsigned s = STG_ID; s < NUM_STG; s++) begin
      if (en_c[s]) vld_d[s] = vld_up[s] && !flush_c[s];
    end
    stall_cnt_d = stall_cnt_q;
    if (!en_c[STG_IF] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      vld_q       <= '0;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign pc_en        = en_c[STG_IF];
  assign if_id_en     = en_c[STG_ID];
  assign id_ex_en     = en_c[STG_EX];
  assign ex_mem_en    = en_c[STG_MEM];
  assign mem_wb_en    = en_c[STG_WB];
  assign if_id_flush  = flush_c[STG_ID];
  assign id_ex_flush  = flush_c[STG_EX];
  assign ex_mem_flush = flush_c[STG_MEM];
  assign mem_wb_flush = flush_c[STG_WB];
  assign id_valid     = vld_q[STG_ID];
  assign ex_valid     = vld_q[STG_EX];
  assign mem_valid    = vld_q[STG_MEM];
  assign wb_valid     = vld_q[STG_WB];
  assign stall_cnt    = stall_cnt_q;
  assign halted       = halted_q;
  assign err          = err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned TIMEOUT = 4;
  localparam int          SAT     = 31;

  logic clk = 1'b0;
  logic reset, imem_ready, id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
  logic mem_req, mem_ready, wb_halt;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic id_valid, ex_valid, mem_valid, wb_valid, halted, err;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .stall_cnt(stall_cnt), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  logic [8:0] obs_ctl;
  logic [3:0] obs_vld;
  assign obs_ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  assign obs_vld = {wb_valid, mem_valid, ex_valid, id_valid};

  // Reference model: stage occupancy, sticky modes, wait and stall tallies
  logic [3:0] m_v = 4'b0;     // [0]=ID [1]=EX [2]=MEM [3]=WB
  logic       m_halt = 1'b0;
  logic       m_err = 1'b0;
  int         m_wait = 0;
  int         m_stall = 0;
  logic [8:0] m_c;

  // Control word per situation: {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}
  function automatic logic [8:0] exp_ctl();
    logic lu;
    lu = m_v[1] && ex_is_load && (ex_rd != 5'd0) && m_v[0] &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_halt || m_err)                  return 9'b00000_0000;
    if (m_v[2] && mem_req && !mem_ready)  return 9'b00001_0001;
    if (m_v[1] && ex_redirect)            return 9'b11111_1100;
    if (lu)                               return 9'b00111_0100;
    if (!imem_ready)                      return 9'b01111_1000;
    return 9'b11111_0000;
  endfunction

  always_comb m_c = exp_ctl();

  always @(posedge clk) begin
    if (reset) begin
      m_v <= 4'b0; m_halt <= 1'b0; m_err <= 1'b0; m_wait <= 0; m_stall <= 0;
    end else begin
      m_v[0] <= m_c[7] ? (imem_ready && !m_c[3]) : m_v[0];
      m_v[1] <= m_c[6] ? (m_v[0] && !m_c[2]) : m_v[1];
      m_v[2] <= m_c[5] ? (m_v[1] && !m_c[1]) : m_v[2];
      m_v[3] <= m_c[4] ? (m_v[2] && !m_c[0]) : m_v[3];
      if (!m_c[8] && m_stall < SAT) m_stall <= m_stall + 1;
      if (!m_halt && !m_err) begin
        if (m_v[3] && wb_halt) m_halt <= 1'b1;
        else if (m_v[2] && mem_req && !mem_ready) begin
          if (m_wait + 1 >= int'(TIMEOUT)) m_err <= 1'b1;
          else m_wait <= m_wait + 1;
        end else m_wait <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    imem_ready = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill(input int n);
    imem_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    tick(); tick();
    #1;
    n_vec++; if (obs_vld !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b expected 0000", obs_vld); end
    n_vec++; if ({stall_cnt, halted, err} !== 7'b0) begin n_err++; $display("FAIL reset_cnt: got cnt=%0d halted=%b err=%b expected 0/0/0", stall_cnt, halted, err); end
    n_vec++; if (obs_ctl !== 9'b11111_0000) begin n_err++; $display("FAIL reset_ctl: got %b expected 111110000", obs_ctl); end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    fill(2);
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    n_vec++; if (obs_ctl !== 9'b00111_0100) begin n_err++; $display("FAIL load_use_ctl: got %b expected 001110100", obs_ctl); end
    tick();
    n_vec++; if ({id_valid, ex_valid, mem_valid} !== 3'b101) begin n_err++; $display("FAIL load_use_bubble: got id/ex/mem=%b expected 101", {id_valid, ex_valid, mem_valid}); end
    n_vec++; if (stall_cnt !== 5'd1) begin n_err++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
    n_vec++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL load_use_release: got pc_en=%b expected 1", pc_en); end
    tick();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    n_vec++; if ({pc_en, id_ex_flush} !== 2'b10) begin n_err++; $display("FAIL load_x0: got pc_en/id_ex_flush=%b expected 10", {pc_en, id_ex_flush}); end
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1;
    #1;
    n_vec++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL load_rs2: got pc_en=%b expected 0", pc_en); end
    id_use_rs2 = 1'b0;
    #1;
    n_vec++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL load_rs2_unused: got pc_en=%b expected 1", pc_en); end
    set_idle();
  endtask

  task automatic test_redirect();
    do_reset();
    fill(2);
    ex_redirect = 1'b1;
    #1;
    n_vec++; if ({pc_en, if_id_flush, id_ex_flush, ex_mem_flush} !== 4'b1110) begin n_err++; $display("FAIL redirect_ctl: got %b expected 1110", {pc_en, if_id_flush, id_ex_flush, ex_mem_flush}); end
    tick();
    ex_redirect = 1'b0;
    #1;
    n_vec++; if ({id_valid, ex_valid, mem_valid} !== 3'b001) begin n_err++; $display("FAIL redirect_valid: got id/ex/mem=%b expected 001", {id_valid, ex_valid, mem_valid}); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    fill(3);
    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (obs_ctl !== 9'b00001_0001) begin n_err++; $display("FAIL mem_stall_ctl[%0d]: got %b expected 000010001", i, obs_ctl); end
      tick();
    end
    n_vec++; if ({wb_valid, stall_cnt} !== {1'b0, 5'd3}) begin n_err++; $display("FAIL mem_wait_cnt: got wb=%b cnt=%0d expected wb=0 cnt=3", wb_valid, stall_cnt); end
    mem_ready = 1'b1;
    #1;
    n_vec++; if ({pc_en, if_id_flush, id_ex_flush, mem_wb_flush} !== 4'b1110) begin n_err++; $display("FAIL mem_ready_redirect: got %b expected 1110", {pc_en, if_id_flush, id_ex_flush, mem_wb_flush}); end
    tick();
    mem_req = 1'b0; ex_redirect = 1'b0;
    #1;
    n_vec++; if (obs_vld !== 4'b1100) begin n_err++; $display("FAIL mem_exit_valid: got wb/mem/ex/id=%b expected 1100", obs_vld); end
    n_vec++; if ({pc_en, stall_cnt} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL mem_exit_run: got pc_en=%b cnt=%0d expected 1/3", pc_en, stall_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    fill(3);
    mem_req = 1'b1; mem_ready = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL timeout_early: got err=%b expected 0", err); end
    tick();
    n_vec++; if ({err, obs_ctl} !== 10'b1_00000_0000) begin n_err++; $display("FAIL timeout_err: got err=%b ctl=%b expected 1/000000000", err, obs_ctl); end
    mem_req = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    n_vec++; if ({err, pc_en, stall_cnt} !== {2'b10, 5'd6}) begin n_err++; $display("FAIL error_sticky: got err=%b pc_en=%b cnt=%0d expected 1/0/6", err, pc_en, stall_cnt); end
    do_reset();
    n_vec++; if ({err, pc_en, stall_cnt} !== {2'b01, 5'd0}) begin n_err++; $display("FAIL error_reset: got err=%b pc_en=%b cnt=%0d expected 0/1/0", err, pc_en, stall_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    fill(4);
    wb_halt = 1'b1;
    #1;
    n_vec++; if ({pc_en, halted} !== 2'b10) begin n_err++; $display("FAIL halt_entry: got pc_en/halted=%b expected 10", {pc_en, halted}); end
    tick();
    wb_halt = 1'b0;
    #1;
    n_vec++; if ({halted, obs_ctl} !== 10'b1_00000_0000) begin n_err++; $display("FAIL halt_ctl: got halted=%b ctl=%b expected 1/000000000", halted, obs_ctl); end
    tick(); tick();
    n_vec++; if ({obs_vld, stall_cnt} !== {4'b1111, 5'd2}) begin n_err++; $display("FAIL halt_hold: got vld=%b cnt=%0d expected 1111/2", obs_vld, stall_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++; if ({halted, obs_vld, stall_cnt, pc_en} !== {1'b0, 4'b0, 5'd0, 1'b1}) begin n_err++; $display("FAIL halt_reset: got halted=%b vld=%b cnt=%0d pc_en=%b expected 0/0000/0/1", halted, obs_vld, stall_cnt, pc_en); end
    tick();
    n_vec++; if ({pc_en, id_valid} !== 2'b11) begin n_err++; $display("FAIL halt_resume: got pc_en/id_valid=%b expected 11", {pc_en, id_valid}); end
  endtask

  task automatic test_saturate();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    n_vec++; if (stall_cnt !== 5'd31) begin n_err++; $display("FAIL stall_saturate: got %0d expected 31", stall_cnt); end
    n_vec++; if ({id_valid, pc_en, if_id_flush} !== 3'b001) begin n_err++; $display("FAIL fetch_miss: got id_valid/pc_en/if_id_flush=%b expected 001", {id_valid, pc_en, if_id_flush}); end
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 39) == 0);
      imem_ready  = ($urandom_range(0, 9) < 8);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_is_load  = ($urandom_range(0, 9) < 4);
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_req     = ($urandom_range(0, 9) < 5);
      mem_ready   = ($urandom_range(0, 9) < 6);
      wb_halt     = ($urandom_range(0, 49) == 0);
      #1;
      n_vec++; if (obs_ctl !== m_c) begin n_err++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, obs_ctl, m_c); end
      n_vec++; if (obs_vld !== m_v) begin n_err++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, obs_vld, m_v); end
      n_vec++; if (stall_cnt !== 5'(m_stall)) begin n_err++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", i, stall_cnt, m_stall); end
      n_vec++; if ({halted, err} !== {m_halt, m_err}) begin n_err++; $display("FAIL rand_sticky[%0d]: got %b expected %b", i, {halted, err}, {m_halt, m_err}); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
